turn_signal_sequencer: RTL and testbench

Parametrised tail-light sequencer: drives LAMPS lamps per side in the classic inner-to-outer "walking" turn pattern, plus a hazard mode that flashes both sides together. The step rate is set by a built-in prescaler, so the block runs from the system clock with no external strobe. It sits between the driver-switch inputs and the lamp drivers in the lighting subsystem. It supersedes the fixed three-lamp, one-step-per-clock sequencer.

---
 rtl/tail_light_pkg.sv | 12 +
 rtl/step_prescaler.sv | 34 +++
 rtl/turn_signal_sequencer.sv | 114 +++++++++++
 tb/tb_turn_signal_sequencer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/tail_light_pkg.sv
// Shared lighting-subsystem types: tail-light sequencer modes.
package tail_light_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEFT    = 3'd1,
    RIGHT   = 3'd2,
    HAZ_ON  = 3'd3,
    HAZ_OFF = 3'd4
  } mode_t;

endpackage

// File: rtl/step_prescaler.sv
// Free-running divider producing a one-clock tick every TICK_DIV clocks.
module step_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  generate
    if (TICK_DIV == 1) begin : g_bypass
      logic unused_inputs;
      assign unused_inputs = clk ^ reset_n;
      assign tick = 1'b1;
    end else begin : g_count
      localparam int CW = $clog2(TICK_DIV);
      localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

      logic [CW-1:0] cnt_q, cnt_d;

      always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
      end

      assign tick = (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/turn_signal_sequencer.sv
// Walking inner-to-outer turn sequencer with hazard flash; Moore lamp decode
// from registered mode/step, stepping only on prescaler ticks.
module turn_signal_sequencer
  import tail_light_pkg::*;
#(
  parameter int LAMPS    = 3,
  parameter int TICK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             left,
  input  logic             right,
  input  logic             hazard,
  output logic [LAMPS-1:0] left_lamps,
  output logic [LAMPS-1:0] right_lamps,
  output logic             active
);

  localparam int SW = $clog2(LAMPS + 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(LAMPS);

  mode_t         mode_q, mode_d;
  logic [SW-1:0] step_q, step_d;
  logic          tick;
  logic          haz_req;
  logic [LAMPS-1:0] fill;

  step_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  assign haz_req = hazard | (left & right);

  always_comb begin
    mode_d = mode_q;
    step_d = step_q;
    if (tick) begin
      unique case (mode_q)
        IDLE: begin
          step_d = '0;
          if (haz_req) begin
            mode_d = HAZ_ON;
          end else if (left) begin
            mode_d = LEFT;
            step_d = SW'(1);
          end else if (right) begin
            mode_d = RIGHT;
            step_d = SW'(1);
          end
        end
        // Turn direction is latched for the whole walk; only hazard aborts it.
        LEFT, RIGHT: begin
          if (haz_req) begin
            mode_d = HAZ_ON;
            step_d = '0;
          end else if (step_q == LAST_STEP) begin
            mode_d = IDLE;
            step_d = '0;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
        HAZ_ON: begin
          mode_d = HAZ_OFF;
          step_d = '0;
        end
        HAZ_OFF: begin
          mode_d = IDLE;
          step_d = '0;
        end
        default: begin
          mode_d = IDLE;
          step_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= IDLE;
      step_q <= '0;
    end else begin
      mode_q <= mode_d;
      step_q <= step_d;
    end
  end

  always_comb begin
    fill        = '0;
    left_lamps  = '0;
    right_lamps = '0;
    for (int i = 0; i < LAMPS; i++) begin
      fill[i] = (i < int'(step_q));
    end
    unique case (mode_q)
      LEFT:    left_lamps  = fill;
      RIGHT:   right_lamps = fill;
      HAZ_ON: begin
        left_lamps  = '1;
        right_lamps = '1;
      end
      default: begin
        left_lamps  = '0;
        right_lamps = '0;
      end
    endcase
  end

  assign active = (mode_q != IDLE);

endmodule

// File: tb/tb_turn_signal_sequencer.sv
// Directed bench for turn_signal_sequencer: main config 3 lamps / div 4,
// plus corner instances 1 lamp / div 1 and 8 lamps / div 4.
module tb_turn_signal_sequencer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  logic       left_a = 0, right_a = 0, hazard_a = 0;
  logic [2:0] left_lamps_a, right_lamps_a;
  logic       active_a;

  logic       left_b = 0, right_b = 0, hazard_b = 0;
  logic [0:0] left_lamps_b, right_lamps_b;
  logic       active_b;

  logic       left_c = 0, right_c = 0, hazard_c = 0;
  logic [7:0] left_lamps_c, right_lamps_c;
  logic       active_c;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  turn_signal_sequencer #(.LAMPS(3), .TICK_DIV(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .left(left_a), .right(right_a), .hazard(hazard_a),
    .left_lamps(left_lamps_a), .right_lamps(right_lamps_a), .active(active_a)
  );

  turn_signal_sequencer #(.LAMPS(1), .TICK_DIV(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .left(left_b), .right(right_b), .hazard(hazard_b),
    .left_lamps(left_lamps_b), .right_lamps(right_lamps_b), .active(active_b)
  );

  turn_signal_sequencer #(.LAMPS(8), .TICK_DIV(4)) dut_c (
    .clk(clk), .reset_n(reset_n), .left(left_c), .right(right_c), .hazard(hazard_c),
    .left_lamps(left_lamps_c), .right_lamps(right_lamps_c), .active(active_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic step_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset with all inputs low; released on a falling edge so the 4th
  // following rising edge is the first tick.
  task automatic do_reset();
    @(negedge clk);
    reset_n = 0;
    left_a = 0; right_a = 0; hazard_a = 0;
    left_b = 0; right_b = 0; hazard_b = 0;
    left_c = 0; right_c = 0; hazard_c = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
  endtask

  task automatic check_a(input string tag, input logic [2:0] l, input logic [2:0] r,
                         input logic act);
    check({tag, " left"},   {29'd0, left_lamps_a},  {29'd0, l});
    check({tag, " right"},  {29'd0, right_lamps_a}, {29'd0, r});
    check({tag, " active"}, {31'd0, active_a},      {31'd0, act});
  endtask

  logic [2:0] left_seq [6] = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b001, 3'b011};
  logic       left_act [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    // Reset state, then idle with inputs low for 20 cycles.
    do_reset();
    check_a("reset", 3'b000, 3'b000, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step_clk(1);
      check_a("idle", 3'b000, 3'b000, 1'b0);
    end

    // Left hold: each value stable for exactly 4 clocks.
    do_reset();
    left_a = 1;
    step_clk(3);
    check_a("left pre-tick", 3'b000, 3'b000, 1'b0);
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 4; c++) begin
        step_clk(1);
        check_a($sformatf("left seq%0d c%0d", k, c), left_seq[k], 3'b000, left_act[k]);
      end
    end

    // Mid-sequence reset while left_lamps=011: goes dark without a clock.
    #1 reset_n = 0;
    #1 check_a("async reset", 3'b000, 3'b000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    step_clk(3);
    check_a("post-reset pre-tick", 3'b000, 3'b000, 1'b0);
    step_clk(1);
    check_a("post-reset 1st tick", 3'b001, 3'b000, 1'b1);

    // Hazard aborts a right sequence at 011, then flashes while held.
    do_reset();
    right_a = 1;
    step_clk(4);
    check_a("right s1", 3'b000, 3'b001, 1'b1);
    step_clk(4);
    check_a("right s2", 3'b000, 3'b011, 1'b1);
    hazard_a = 1;
    step_clk(1);
    check_a("haz wait tick", 3'b000, 3'b011, 1'b1);
    step_clk(3);
    check_a("haz on", 3'b111, 3'b111, 1'b1);
    step_clk(4);
    check_a("haz off", 3'b000, 3'b000, 1'b1);
    step_clk(4);
    check_a("haz idle", 3'b000, 3'b000, 1'b0);
    step_clk(4);
    check_a("haz on again", 3'b111, 3'b111, 1'b1);

    // Both switches from IDLE behave as hazard.
    do_reset();
    left_a = 1; right_a = 1;
    step_clk(4);
    check_a("both on", 3'b111, 3'b111, 1'b1);
    step_clk(4);
    check_a("both off", 3'b000, 3'b000, 1'b1);

    // Releasing left mid-sequence does not cut the walk short.
    do_reset();
    left_a = 1;
    step_clk(4);
    check_a("release s1", 3'b001, 3'b000, 1'b1);
    left_a = 0;
    step_clk(4);
    check_a("release s2", 3'b011, 3'b000, 1'b1);
    step_clk(4);
    check_a("release s3", 3'b111, 3'b000, 1'b1);
    step_clk(4);
    check_a("release idle", 3'b000, 3'b000, 1'b0);
    step_clk(4);
    check_a("release stays idle", 3'b000, 3'b000, 1'b0);

    // LAMPS=1, TICK_DIV=1: toggles every clock.
    do_reset();
    left_b = 1;
    for (int i = 0; i < 6; i++) begin
      step_clk(1);
      check($sformatf("l1 toggle %0d", i), {31'd0, left_lamps_b}, {31'd0, ~i[0]});
      check($sformatf("l1 right %0d", i),  {31'd0, right_lamps_b}, 32'd0);
    end

    // LAMPS=8: nine ticks per repetition.
    do_reset();
    left_c = 1;
    for (int k = 1; k <= 10; k++) begin
      logic [31:0] exp_c;
      step_clk(4);
      if (k <= 8)       exp_c = (32'd1 << k) - 32'd1;
      else if (k == 9)  exp_c = 32'd0;
      else              exp_c = 32'd1;
      check($sformatf("l8 tick %0d", k), {24'd0, left_lamps_c}, exp_c);
    end
    check("l8 right", {24'd0, right_lamps_c}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
